// File: rtl/wb_native_slave.sv
// Wishbone classic slave bridging bus cycles onto a picorv32-style native memory port.
// Decodes an address window, times out stalled native requests, and drains aborted cycles.
module wb_native_slave #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, MEM, DRAIN, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        dat_d, addr_d, wdata_d;
    logic [3:0]         wstrb_d;
    logic               valid_d, ack_d, err_d, busy_d;
    logic               hit, timeout_hit;

    assign hit         = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    // Fires on the MEM/DRAIN cycle whose increment would make the count reach the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wbs_dat_o <= dat_d;
            wbs_ack_o <= ack_d;
            wbs_err_o <= err_d;
            mem_valid <= valid_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wstrb <= wstrb_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = wbs_dat_o;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        valid_d = mem_valid;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (!hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (wbs_we_i && (wbs_sel_i == 4'b0000)) begin
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = wbs_adr_i;
                        wdata_d = wbs_dat_i;
                        wstrb_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = MEM;
                    end
                end
            end
            MEM: begin
                if (mem_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    if (mem_wstrb == 4'b0000)
                        dat_d = mem_rdata;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    // An aborted master gets no error; the request is simply dropped.
                    valid_d = 1'b0;
                    err_d   = wbs_cyc_i;
                    state_d = wbs_cyc_i ? RESP : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!wbs_cyc_i)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ready || timeout_hit) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_wb_native_slave.sv
// Directed bench for wb_native_slave: one default instance and one with a 4-cycle timeout,
// both driven from the same bus and native-side stimulus.
module tb_wb_native_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat_i, rdata;
    logic        we, stb, cyc, ready;
    logic [3:0]  sel;

    logic [31:0] dat_o, m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        ack, err, m_valid, busy;

    logic [31:0] dat_o_t, m_addr_t, m_wdata_t;
    logic [3:0]  m_wstrb_t;
    logic        ack_t, err_t, m_valid_t, busy_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_native_slave dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_ack_o(ack), .wbs_err_o(err),
        .mem_valid(m_valid), .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
        .mem_ready(ready), .mem_rdata(rdata), .busy(busy)
    );

    wb_native_slave #(.TIMEOUT_CYCLES(4)) dut_to (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o_t),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_ack_o(ack_t), .wbs_err_o(err_t),
        .mem_valid(m_valid_t), .mem_addr(m_addr_t), .mem_wdata(m_wdata_t), .mem_wstrb(m_wstrb_t),
        .mem_ready(ready), .mem_rdata(rdata), .busy(busy_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d);
        adr = a; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic release_bus;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat_i = '0; rdata = '0;
        we = 1'b0; stb = 1'b0; cyc = 1'b0; ready = 1'b0; sel = '0;
        tick; tick;
        check("rst_valid", m_valid, 0);
        check("rst_ack_err", {ack, err}, 0);
        check("rst_busy", busy, 0);
        check("rst_dat", dat_o, 0);
        check("rst_wstrb", m_wstrb, 0);
        rst_n = 1'b1;
        tick;
        check("idle_no_req", m_valid, 0);

        // Read with a zero-wait memory: ack two edges after the request is sampled.
        request(32'h0000_0010, 1'b0, 4'hF, 32'h0);
        tick;
        check("rd_valid", m_valid, 1);
        check("rd_addr", m_addr, 32'h0000_0010);
        check("rd_wstrb", m_wstrb, 0);
        check("rd_busy", busy, 1);
        check("rd_no_ack_yet", {ack, err}, 0);
        ready = 1'b1; rdata = 32'hDEAD_BEEF;
        tick;
        check("rd_ack", {ack, err}, 2'b10);
        check("rd_data", dat_o, 32'hDEAD_BEEF);
        check("rd_valid_drop", m_valid, 0);
        ready = 1'b0; rdata = 32'h0;
        release_bus;
        tick;
        check("rd_ack_pulse", {ack, err}, 0);
        check("rd_idle", busy, 0);

        // Write with three wait states; the timeout instance sees ready and timeout together.
        request(32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678);
        tick;
        check("wr_valid", m_valid, 1);
        check("wr_wstrb", m_wstrb, 4'b0011);
        check("wr_wdata", m_wdata, 32'h1234_5678);
        dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("wr_wait_valid", m_valid, 1);
            check("wr_wait_ack", ack, 0);
            check("wr_wdata_held", m_wdata, 32'h1234_5678);
        end
        ready = 1'b1;
        tick;
        check("wr_ack", {ack, err}, 2'b10);
        check("wr_dat_kept", dat_o, 32'hDEAD_BEEF);
        check("wr_valid_drop", m_valid, 0);
        check("coincide_ack_t", {ack_t, err_t}, 2'b10);
        check("coincide_wstrb_t", m_wstrb_t, 4'b0011);
        check("coincide_wdata_t", m_wdata_t, 32'h1234_5678);
        check("coincide_dat_t", dat_o_t, 32'hDEAD_BEEF);
        ready = 1'b0;
        release_bus;
        tick;
        check("wr_done", {ack, err, busy}, 0);

        // Window miss, then a write with no byte lanes selected.
        request(32'h0100_0000, 1'b0, 4'hF, 32'h0);
        tick;
        check("miss_err", {ack, err}, 2'b01);
        check("miss_no_valid", m_valid, 0);
        release_bus;
        tick;
        check("miss_clear", {ack, err, busy, m_valid}, 0);
        request(32'h0000_0030, 1'b1, 4'b0000, 32'hAAAA_5555);
        tick;
        check("sel0_ack", {ack, err}, 2'b10);
        check("sel0_no_valid", m_valid, 0);
        release_bus;
        tick;
        check("sel0_clear", {ack, err, busy}, 0);

        // Timeout: memory never answers.
        request(32'h0000_0040, 1'b0, 4'hF, 32'h0);
        tick;
        check("to_addr_t", m_addr_t, 32'h0000_0040);
        for (int i = 0; i < 4; i++) begin
            check("to_valid_held_t", m_valid_t, 1);
            check("to_no_err_yet_t", err_t, 0);
            tick;
        end
        check("to_valid_drop_t", m_valid_t, 0);
        check("to_err_t", {ack_t, err_t}, 2'b01);
        check("to_busy_resp_t", busy_t, 1);
        release_bus;
        tick;
        check("to_err_pulse_t", {ack_t, err_t}, 0);
        check("to_busy_t", busy_t, 0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        check("reinit_idle", {busy, m_valid}, 0);

        // Master abort: DRAIN holds the native request until memory answers.
        request(32'h0000_0050, 1'b0, 4'hF, 32'h0);
        tick;
        check("ab_valid", m_valid, 1);
        release_bus;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("ab_drain_valid", m_valid, 1);
            check("ab_drain_resp", {ack, err}, 0);
            check("ab_drain_busy", busy, 1);
        end
        ready = 1'b1; rdata = 32'h5555_AAAA;
        tick;
        check("ab_valid_drop", m_valid, 0);
        check("ab_no_resp", {ack, err}, 0);
        check("ab_idle", busy, 0);
        check("ab_dat_kept", dat_o, 32'h0);
        ready = 1'b0;
        request(32'h0000_0060, 1'b0, 4'hF, 32'h0);
        tick;
        check("ab_next_valid", m_valid, 1);
        check("ab_next_addr", m_addr, 32'h0000_0060);
        ready = 1'b1; rdata = 32'hCAFE_F00D;
        tick;
        check("ab_next_ack", {ack, err}, 2'b10);
        check("ab_next_data", dat_o, 32'hCAFE_F00D);
        ready = 1'b0;
        release_bus;
        tick;

        // Asynchronous reset in the middle of a native access.
        request(32'h0000_0070, 1'b0, 4'hF, 32'h0);
        tick;
        check("rm_valid_pre", {m_valid, busy}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_valid_async", m_valid, 0);
        check("rm_busy_async", busy, 0);
        check("rm_resp_async", {ack, err}, 0);
        check("rm_addr_async", m_addr, 0);
        check("rm_dat_async", dat_o, 0);
        tick;
        check("rm_held", {m_valid, ack, err, busy}, 0);
        rst_n = 1'b1;
        request(32'h0000_0080, 1'b0, 4'hF, 32'h0);
        tick;
        check("rm_post_valid", m_valid, 1);
        ready = 1'b1; rdata = 32'h0BAD_F00D;
        tick;
        check("rm_post_ack", {ack, err}, 2'b10);
        check("rm_post_data", dat_o, 32'h0BAD_F00D);
        ready = 1'b0;
        release_bus;
        tick;
        check("rm_post_idle", {ack, err, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_native_slave.md
Name: wb_native_slave

Overview:
- Wishbone classic slave (responder) that bridges bus cycles onto a picorv32-style native memory port (mem_valid/mem_ready) feeding on-chip RAM or peripherals.
- Completes the path from the CPU-side Wishbone master to native-interface targets.
- Adds address-window decode, a bus-timeout error response, and safe handling of master-aborted cycles.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base; a request hits when (wbs_adr_i & ADDR_MASK) == BASE_ADDR.
- ADDR_MASK, 32'hFF00_0000: window decode mask.
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before an error is returned; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o is high.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle valid.
- wbs_ack_o  out  1  normal termination, one-cycle pulse.
- wbs_err_o  out  1  error termination, one-cycle pulse.
- mem_valid  out  1  native request valid.
- mem_addr  out  32  native address.
- mem_wdata  out  32  native write data.
- mem_wstrb  out  4  byte strobes; 0 means read.
- mem_ready  in  1  native completion.
- mem_rdata  in  32  native read data, sampled when mem_ready is high.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State goes to IDLE and the timeout counter clears.
  - All outputs go to 0, including wbs_dat_o, mem_addr, mem_wdata and mem_wstrb.
  - Asserting reset mid-transaction drops mem_valid immediately. No ack or err is produced.
- States: IDLE, MEM, DRAIN, RESP. All outputs are registered.
- IDLE, when wbs_cyc_i & wbs_stb_i are high:
  - Miss (address outside the window): go to RESP with err=1. No native access.
  - wbs_we_i=1 with wbs_sel_i=0: go to RESP with ack=1. No native access, no state change.
  - Otherwise:
    - Latch mem_addr=wbs_adr_i and mem_wdata=wbs_dat_i.
    - Set mem_wstrb = wbs_we_i ? wbs_sel_i : 4'b0.
    - Assert mem_valid, clear the counter, go to MEM.
- MEM:
  - mem_valid and all mem_* outputs stay stable until completion.
  - On mem_ready:
    - mem_valid<=0 and ack<=1, go to RESP.
    - Reads load wbs_dat_o<=mem_rdata; writes leave wbs_dat_o unchanged.
  - Timeout (TIMEOUT_CYCLES>0): the counter increments each MEM cycle without mem_ready. When it reaches TIMEOUT_CYCLES, set mem_valid<=0 and err<=1, go to RESP.
  - mem_ready has priority over timeout in the same cycle.
  - If wbs_cyc_i drops while mem_ready is low: go to DRAIN (master abort).
- DRAIN:
  - mem_valid stays high; a native request cannot be withdrawn.
  - On mem_ready or timeout: mem_valid<=0, go to IDLE. No ack, no err, wbs_dat_o unchanged.
- RESP:
  - ack or err is high for exactly this one cycle, then both clear and the state returns to IDLE.
  - ack and err are never high together.
  - The next request is sampled no earlier than the following IDLE cycle.
- Latency: request sampled in cycle N, mem_valid visible in N+1. With mem_ready in N+1, ack is in N+2 (minimum 2 cycles). A window miss gives err in N+1.
- mem_ready while mem_valid is low is ignored.
- wbs_stb_i/wbs_cyc_i low in IDLE: no action. Strobe or data changes after acceptance are ignored (values are latched).

Test Plan:
- Read at 0x0000_0010, memory returns 0xDEAD_BEEF with mem_ready one cycle after mem_valid -> mem_wstrb=0, wbs_dat_o=0xDEAD_BEEF, single ack pulse 2 cycles after stb sampled, err never high.
- Write 0x1234_5678 to 0x0000_0020 with sel=4'b0011, 3 memory wait states -> mem_wstrb=4'b0011, mem_wdata=0x1234_5678, mem_valid high 4 cycles, ack one cycle later, wbs_dat_o unchanged.
- Access to 0x0100_0000 (outside the window) -> err pulse in the cycle after the request, mem_valid never asserted; write with sel=0 -> ack, no mem_valid.
- TIMEOUT_CYCLES=4, mem_ready held low -> mem_valid drops after 4 MEM cycles, one err pulse, busy back to 0; mem_ready and timeout coinciding -> ack, not err.
- wbs_cyc_i dropped during MEM, mem_ready arrives 5 cycles later -> DRAIN holds mem_valid until mem_ready, no ack/err, then a new read completes normally.
- wb_rst_ni asserted mid-MEM -> mem_valid, busy, wbs_ack_o and wbs_err_o go to 0 immediately (asynchronously). After release, a read completes with the standard 2-cycle latency.
